pid_update_scheduler: RTL and testbench

Frame scheduler that sequences the per-motor PIDController instances. At a programmable control period it sweeps the enabled motors in index order. For each motor it issues a clean rising-edge `update_controller` strobe, gated on fresh sensor data, and it flags stale sensors and frame overruns. It sits between the register bank and the PIDController array in the motor-control fabric.

---
 rtl/pid_sched_pkg.sv | 9 +
 rtl/period_timer.sv | 28 ++
 rtl/pid_update_scheduler.sv | 114 +++++++++++
 tb/tb_pid_update_scheduler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pid_sched_pkg.sv
// pid_sched_pkg: shared FSM state type, strobe timing defaults and saturating counter helper for the PID update scheduler
package pid_sched_pkg;
  typedef enum logic [2:0] {IDLE, EVAL, HIGH, LOW, NEXT} sched_state_t;
  localparam int DEF_HIGH_CYCLES = 2;
  localparam int DEF_LOW_CYCLES = 2;
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return &v ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/period_timer.sv
// period_timer: reloadable down-counter (clock, reset active-low async, enable, period in; one-cycle tick out every period cycles)
module period_timer #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic [W-1:0] period,
  output logic         tick
);
  logic [W-1:0] count, reload;
  logic armed, run;
  always_comb begin
    run = enable && period != '0;
    reload = period != '0 ? period - 1'b1 : '0;
    tick = run && armed && count == '0;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      count <= '0;
      armed <= 1'b0;
    end else if (!run || !armed || count == '0) begin
      count <= reload;
      armed <= period != '0;
    end else begin
      count <= count - 1'b1;
    end
endmodule

// File: rtl/pid_update_scheduler.sv
// pid_update_scheduler: per-frame sweep of enabled motors issuing fresh-data-gated update strobes, with stale/overrun status
module pid_update_scheduler import pid_sched_pkg::*; #(
  parameter int NUM_MOTORS = 6,
  parameter int HIGH_CYCLES = DEF_HIGH_CYCLES,
  parameter int LOW_CYCLES = DEF_LOW_CYCLES,
  localparam int IW = NUM_MOTORS > 1 ? $clog2(NUM_MOTORS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [31:0]           control_period,
  input  logic [NUM_MOTORS-1:0] motor_enable,
  input  logic [NUM_MOTORS-1:0] sensor_valid,
  input  logic                  clear_status,
  output logic [NUM_MOTORS-1:0] update_controller,
  output logic [IW-1:0]         active_motor,
  output logic                  busy,
  output logic                  frame_start,
  output logic                  frame_done,
  output logic                  overrun,
  output logic [15:0]           overrun_count,
  output logic [NUM_MOTORS-1:0] stale
);
  localparam int PW = $clog2(HIGH_CYCLES > LOW_CYCLES ? HIGH_CYCLES : LOW_CYCLES) + 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_MOTORS - 1);
  sched_state_t state;
  logic [IW-1:0] idx;
  logic [PW-1:0] phase;
  logic [NUM_MOTORS-1:0] mask_q, fresh, sel, stale_set;
  logic tick, eligible, serve, ovr_set;
  period_timer #(.W(32)) u_frame_timer (
    .clock (clock),
    .reset (reset),
    .enable(enable),
    .period(control_period),
    .tick  (tick)
  );
  always_comb begin
    sel = NUM_MOTORS'(1) << idx;
    eligible = state == EVAL && enable && |(sel & mask_q);
    serve = eligible && |(sel & fresh);
    stale_set = eligible && !serve ? sel : '0;
    ovr_set = tick && state != IDLE;
    busy = state != IDLE;
    active_motor = idx;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      idx <= '0;
      phase <= '0;
      mask_q <= '0;
      update_controller <= '0;
      frame_start <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: if (tick) begin
          mask_q <= motor_enable;
          idx <= '0;
          frame_start <= 1'b1;
          state <= EVAL;
        end
        EVAL: if (!enable) begin
          idx <= '0;
          state <= IDLE;
        end else if (serve) begin
          update_controller <= sel;
          phase <= PW'(HIGH_CYCLES - 1);
          state <= HIGH;
        end else begin
          state <= NEXT;
        end
        HIGH: if (phase == '0) begin
          update_controller <= '0;
          phase <= PW'(LOW_CYCLES - 1);
          state <= LOW;
        end else begin
          phase <= phase - 1'b1;
        end
        LOW: if (phase != '0) begin
          phase <= phase - 1'b1;
        end else if (!enable) begin
          idx <= '0;
          state <= IDLE;
        end else begin
          state <= NEXT;
        end
        NEXT: if (!enable || idx == LAST) begin
          frame_done <= enable;
          idx <= '0;
          state <= IDLE;
        end else begin
          idx <= idx + 1'b1;
          state <= EVAL;
        end
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      fresh <= '0;
      stale <= '0;
      overrun <= 1'b0;
      overrun_count <= '0;
    end else begin
      fresh <= (fresh & ~(serve ? sel : '0)) | sensor_valid;
      stale <= (clear_status ? '0 : stale) | stale_set;
      overrun <= ovr_set || (overrun && !clear_status);
      overrun_count <= ovr_set ? sat_inc16(clear_status ? 16'd0 : overrun_count) : clear_status ? 16'd0 : overrun_count;
    end
endmodule

// File: tb/tb_pid_update_scheduler.sv
// tb_pid_update_scheduler: table-driven frame vectors plus strobe scoreboard and hand sequences for overrun, disable, reset and races
module tb_pid_update_scheduler;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b1;
  logic [31:0] control_period = 32'd40;
  logic [3:0] motor_enable = '0, sensor_valid = '0;
  logic clear_status = 1'b0;
  logic [3:0] update_controller, stale;
  logic [1:0] active_motor;
  logic busy, frame_start, frame_done, overrun;
  logic [15:0] overrun_count;
  int applied = 0, miscompares = 0;
  int sbq[$];
  int hi_len = 0, lo_len = 100, e;
  logic [3:0] prev_uc = '0;
  logic mon_on = 1'b0;
  typedef struct {
    logic [3:0] mask;
    logic [3:0] valid;
    logic [3:0] exp_strobe;
    logic [3:0] exp_stale;
    int exp_len;
  } vec_t;
  vec_t vecs[7];
  always #5 clock = ~clock;
  pid_update_scheduler #(.NUM_MOTORS(4), .HIGH_CYCLES(2), .LOW_CYCLES(2)) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .control_period(control_period),
    .motor_enable(motor_enable),
    .sensor_valid(sensor_valid),
    .clear_status(clear_status),
    .update_controller(update_controller),
    .active_motor(active_motor),
    .busy(busy),
    .frame_start(frame_start),
    .frame_done(frame_done),
    .overrun(overrun),
    .overrun_count(overrun_count),
    .stale(stale)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic wait_for(input int s, input logic [3:0] val, input int bound, output int n);
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < bound) begin
      @(negedge clock);
      n++;
      hit = s == 0 ? frame_start : s == 1 ? frame_done : update_controller == val;
    end
    if (!hit) chk($sformatf("timeout_wait%0d", s), 32'(hit), 1);
  endtask
  task automatic push_mask(input logic [3:0] m);
    for (int b = 0; b < 4; b++) if (m[b]) sbq.push_back(b);
  endtask
  always @(negedge clock) begin
    if (mon_on && update_controller != prev_uc) begin
      if (prev_uc == '0) begin
        chk("strobe_onehot", 32'($onehot(update_controller)), 1);
        chk("strobe_gap", 32'(lo_len >= 2), 1);
        if (sbq.size() == 0) chk("unexpected_strobe", 32'(update_controller), 0);
        else begin
          e = sbq.pop_front();
          chk("strobe_order", 32'(update_controller), 32'(1) << e);
        end
        hi_len = 1;
      end else if (update_controller == '0) begin
        chk("strobe_width", hi_len, 2);
        lo_len = 1;
      end else chk("strobe_switch", 32'(update_controller), 0);
    end else if (update_controller != '0) hi_len++;
    else lo_len++;
    if (!mon_on) lo_len = 100;
    prev_uc = update_controller;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int n, n1, n2;
    logic fd_seen;
    vecs[0] = '{4'hF, 4'hF, 4'hF, 4'h0, 25};
    vecs[1] = '{4'hB, 4'h9, 4'h9, 4'h2, 17};
    vecs[2] = '{4'h0, 4'h0, 4'h0, 4'h0, 9};
    vecs[3] = '{4'h5, 4'hF, 4'h5, 4'h0, 17};
    vecs[4] = '{4'hA, 4'h0, 4'hA, 4'h0, 17};
    vecs[5] = '{4'hF, 4'h4, 4'h4, 4'hB, 13};
    vecs[6] = '{4'h8, 4'h8, 4'h8, 4'h0, 13};
    repeat (3) @(negedge clock);
    chk("rst_uc", 32'(update_controller), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fs_fd", 32'({frame_start, frame_done}), 0);
    chk("rst_status", 32'({overrun, stale, active_motor}), 0);
    chk("rst_count", 32'(overrun_count), 0);
    reset = 1'b1;
    mon_on = 1'b1;
    for (int v = 0; v < 7; v++) begin
      motor_enable = vecs[v].mask;
      sensor_valid = vecs[v].valid;
      clear_status = 1'b1;
      @(negedge clock);
      sensor_valid = '0;
      clear_status = 1'b0;
      push_mask(vecs[v].exp_strobe);
      wait_for(0, '0, 100, n);
      @(negedge clock);
      chk($sformatf("v%0d_first_strobe", v), 32'(update_controller), 32'(vecs[v].exp_strobe[0]));
      wait_for(1, '0, 60, n);
      chk($sformatf("v%0d_sweep_len", v), n + 2, vecs[v].exp_len);
      chk($sformatf("v%0d_stale", v), 32'(stale), 32'(vecs[v].exp_stale));
      chk($sformatf("v%0d_overrun", v), 32'(overrun), 0);
      chk($sformatf("v%0d_sb_empty", v), sbq.size(), 0);
    end
    control_period = 32'd20;
    motor_enable = 4'hF;
    sensor_valid = 4'hF;
    clear_status = 1'b1;
    @(negedge clock);
    clear_status = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_for(0, '0, 60, n);
      push_mask(4'hF);
      wait_for(1, '0, 40, n);
      chk($sformatf("ovr%0d_flag", k), 32'(overrun), 1);
      chk($sformatf("ovr%0d_count", k), 32'(overrun_count), k + 1);
      chk($sformatf("ovr%0d_sb_empty", k), sbq.size(), 0);
    end
    control_period = 32'd40;
    clear_status = 1'b1;
    @(negedge clock);
    clear_status = 1'b0;
    chk("clear_overrun", 32'(overrun), 0);
    chk("clear_count", 32'(overrun_count), 0);
    wait_for(0, '0, 60, n);
    push_mask(4'hF);
    repeat (5) @(negedge clock);
    control_period = 32'd60;
    wait_for(1, '0, 40, n1);
    wait_for(0, '0, 100, n2);
    chk("period_old_used", 5 + n1 + n2, 40);
    push_mask(4'hF);
    wait_for(0, '0, 100, n);
    chk("period_new_used", n, 60);
    push_mask(4'h3);
    wait_for(2, 4'h2, 30, n);
    enable = 1'b0;
    @(negedge clock);
    chk("dis_strobe_held", 32'(update_controller), 32'h2);
    @(negedge clock);
    chk("dis_low1", 32'({busy, update_controller}), 32'h10);
    @(negedge clock);
    chk("dis_low2", 32'({busy, update_controller}), 32'h10);
    @(negedge clock);
    chk("dis_idle", 32'({busy, active_motor}), 0);
    fd_seen = 1'b0;
    repeat (6) begin
      fd_seen = fd_seen | frame_done;
      @(negedge clock);
    end
    chk("dis_no_done", 32'(fd_seen), 0);
    chk("dis_sb_empty", sbq.size(), 0);
    control_period = 32'd40;
    enable = 1'b1;
    wait_for(0, '0, 100, n);
    push_mask(4'h7);
    wait_for(2, 4'h4, 40, n);
    mon_on = 1'b0;
    #2 reset = 1'b0;
    sensor_valid = '0;
    #1;
    chk("arst_uc", 32'(update_controller), 0);
    chk("arst_busy", 32'({busy, active_motor}), 0);
    chk("arst_status", 32'({overrun, stale, overrun_count}), 0);
    chk("arst_pulses", 32'({frame_start, frame_done}), 0);
    sbq.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    mon_on = 1'b1;
    wait_for(0, '0, 100, n);
    chk("arst_first_tick", n, 41);
    wait_for(1, '0, 40, n);
    chk("arst_fresh_cleared", 32'(stale), 32'hF);
    sensor_valid = 4'hF;
    clear_status = 1'b1;
    @(negedge clock);
    sensor_valid = '0;
    clear_status = 1'b0;
    push_mask(4'hF);
    wait_for(2, 4'h1, 60, n);
    sensor_valid = 4'h1;
    @(negedge clock);
    sensor_valid = '0;
    wait_for(1, '0, 40, n);
    chk("race_stale", 32'(stale), 0);
    motor_enable = 4'h1;
    push_mask(4'h1);
    wait_for(0, '0, 60, n);
    wait_for(1, '0, 40, n);
    chk("race_fresh_kept", 32'(stale), 0);
    chk("race_sb_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
